// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core's multiply/divide unit:
// opcode encodings, controller states and the default iteration count.
package mips_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

endpackage : mips_pkg

// File: rtl/md_step.sv
// One iteration of the multiply/divide datapath: a shift-add multiply step
// or a restoring-divide step on a 2*WIDTH accumulator.
module md_step
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted_rem;
    logic [WIDTH:0] trial;

    // NOTE: every output of a combinational block is assigned on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        sum         = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        shifted_rem = acc_i[2*WIDTH-1:WIDTH-1];
        trial       = shifted_rem - {1'b0, opnd_i};
        if (is_div) begin
            // Bit WIDTH of the trial difference is set exactly when it went negative.
            if (trial[WIDTH]) begin
                acc_o = {shifted_rem[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule : md_step

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Works on magnitudes for WIDTH steps, then applies the sign fix-up and commits.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] acc_step;
    logic               req_signed, req_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_step)
    );

    always_comb begin
        req_signed = (op == MD_MULT) || (op == MD_DIV);
        req_div    = (op == MD_DIV)  || (op == MD_DIVU);
        a_neg      = req_signed && a[WIDTH-1];
        b_neg      = req_signed && b[WIDTH-1];
        a_mag      = a_neg ? -a : a;
        b_mag      = b_neg ? -b : b;
    end

    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    case (md_op_t'(op))
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            is_div_d = req_div;
                            if (req_div) begin
                                acc_d  = {{WIDTH{1'b0}}, a_mag};
                                opnd_d = b_mag;
                                // A zero divisor yields an all-ones quotient that must stay
                                // unsigned; the remainder then re-signs back to the raw dividend.
                                neg_res_d = (a_neg ^ b_neg) && (b != '0);
                            end else begin
                                acc_d     = {{WIDTH{1'b0}}, b_mag};
                                opnd_d    = a_mag;
                                neg_res_d = a_neg ^ b_neg;
                            end
                            neg_rem_d = a_neg;
                            cnt_d     = '0;
                            state_d   = MD_RUN;
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            MD_RUN: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = MD_FIX;
                    end
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                if (!flush) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != MD_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule : mul_div_unit

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: an arithmetic reference model fills a
// scoreboard at issue time and each done pulse pops and compares HI/LO.
module tb_mul_div_unit;
    import mips_pkg::*;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op    = '0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int           checks   = 0;
    int           failures = 0;
    logic [63:0]  sb_q[$];
    logic [W-1:0] sh_hi = '0;
    logic [W-1:0] sh_lo = '0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo} from native 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            MD_MULT:  return 64'(sx * sy);
            MD_MULTU: return ux * uy;
            MD_DIV: begin
                if (y == '0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (y == '0) return {x, 32'hFFFF_FFFF};
                return {32'(ux % uy), 32'(ux / uy)};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Single-cycle request that must not start an iterative operation.
    task automatic idle_req(input logic [2:0] o, input logic [W-1:0] d, input logic fl, input string tag);
        @(negedge clk);
        start = 1'b1; op = o; a = d; b = '0; flush = fl;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        if (!fl && o == MD_MTHI) sh_hi = d;
        if (!fl && o == MD_MTLO) sh_lo = d;
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_hi"},   64'(hi),   64'(sh_hi));
        check({tag, "_lo"},   64'(lo),   64'(sh_lo));
    endtask

    // Issue an iterative op; optionally re-strobe start, flush, or reset mid-run.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int retrig_at, input int flush_at, input int reset_at, input string tag);
        logic [63:0] e;
        int n;
        int early;
        if (flush_at == 0 && reset_at == 0) sb_q.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        early = 0;
        while (busy === 1'b1 && n < 60) begin
            if (done) early++;
            if (n == 16) begin
                check({tag, "_hold_hi"}, 64'(hi), 64'(sh_hi));
                check({tag, "_hold_lo"}, 64'(lo), 64'(sh_lo));
            end
            if (retrig_at != 0 && n == retrig_at) begin
                start = 1'b1; op = MD_MTLO; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            flush = (flush_at != 0 && n == flush_at);
            if (reset_at != 0 && n == reset_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_busy"}, 64'(busy), 64'd0);
                check({tag, "_done"}, 64'(done), 64'd0);
                check({tag, "_hi"},   64'(hi),   64'd0);
                check({tag, "_lo"},   64'(lo),   64'd0);
                sh_hi = '0;
                sh_lo = '0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        flush = 1'b0;
        check({tag, "_early_done"}, 64'(early), 64'd0);
        if (flush_at != 0) begin
            check({tag, "_busy_cycles"}, 64'(n), 64'(flush_at + 1));
            early = 0;
            repeat (40) begin
                if (done) early++;
                @(negedge clk);
            end
            check({tag, "_no_done"}, 64'(early), 64'd0);
            check({tag, "_hi"}, 64'(hi), 64'(sh_hi));
            check({tag, "_lo"}, 64'(lo), 64'(sh_lo));
            return;
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'd33);
        check({tag, "_done"}, 64'(done), 64'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            sh_hi = e[63:32];
            sh_lo = e[31:0];
            check({tag, "_hi"}, 64'(hi), 64'(sh_hi));
            check({tag, "_lo"}, 64'(lo), 64'(sh_lo));
        end
        @(negedge clk);
        check({tag, "_done_fall"}, 64'(done), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(MD_MULT,  32'hFFFF_FFFF, 32'd2,         0, 0, 0, "mult_neg");
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2,         0, 0, 0, "multu_big");
        run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 0, 0, 0, "mult_minmin");
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         0, 0, 0, "div_neg");
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "div_ovf");
        run_op(MD_DIVU,  32'd7,         32'd0,         0, 0, 0, "divu_zero");
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd0,         0, 0, 0, "div_zero_neg");
        run_op(MD_DIVU,  32'hFFFF_FFFF, 32'd10,        0, 0, 0, "divu_big");

        idle_req(MD_MTHI, 32'h1234_5678, 1'b0, "mthi");
        run_op(MD_MULTU, 32'd3,   32'd5, 10, 0, 0, "multu_retrig");
        run_op(MD_DIVU,  32'd100, 32'd7, 0, 10, 0, "divu_flush");
        idle_req(MD_MTHI, 32'hCAFE_F00D, 1'b1, "flush_start");
        idle_req(3'd6,    32'h0000_0055, 1'b0, "reserved");

        run_op(MD_MULT, 32'd1234, 32'd5678, 0, 0, 20, "reset_mid");
        idle_req(MD_MTLO, 32'hA5A5_A5A5, 1'b0, "mtlo");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mul_div_unit
